// File: rtl/data_stream_cache_pkg.sv
// data_stream_cache_pkg
//   Shared definitions for the data stream cache and its consumer (HashCore):
//   the 2-bit stream state encoding and a constant log2 helper used to size
//   counters from parameters.
package data_stream_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of bits needed to represent values 0 .. value-1 (minimum 1).
    // Call with N+1 to get a width able to hold the value N itself.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_stream_cache_if.sv
// data_stream_cache_if
//   Bundles the stream-side signals of the cache.
//
//   Handshake rules (both directions):
//     - Push: a word is transferred on a rising edge where in_valid and
//       in_ready are both high. in_ready never depends on in_valid.
//     - Pop: a word is removed on a rising edge where DataRequest is high and
//       the cache holds at least one word in LOAD/TAIL. CacheEnough is only
//       advisory; the popped word appears on DataStream one cycle later and
//       holds until the next pop. A DataRequest that cannot be served sets
//       the sticky underflow flag instead.
//
//   Signals:
//     start        producer -> cache  one-cycle pulse, begins a new stream
//     in_valid     producer -> cache  upstream word valid
//     in_data      producer -> cache  upstream word
//     in_ready     cache -> producer  cache accepts a word this cycle
//     DataRequest  consumer -> cache  pop one word this cycle
//     CacheEnough  cache -> consumer  a pop is allowed
//     DataStream   cache -> consumer  popped word (registered)
//     level        cache -> consumer  number of words held
//     stream_done  cache -> consumer  whole stream has been popped
//     underflow    cache -> consumer  sticky, pop seen while nothing to pop
interface data_stream_cache_if #(
    parameter int DATA_INDEX_WIDTH = 32,
    parameter int CACHE_DEPTH_BIT  = 4
);
    logic                        start;
    logic                        in_valid;
    logic [DATA_INDEX_WIDTH-1:0] in_data;
    logic                        in_ready;
    logic                        DataRequest;
    logic                        CacheEnough;
    logic [DATA_INDEX_WIDTH-1:0] DataStream;
    logic [CACHE_DEPTH_BIT:0]    level;
    logic                        stream_done;
    logic                        underflow;

    // Driving side (producer and consumer of the stream).
    modport master (
        output start, in_valid, in_data, DataRequest,
        input  in_ready, CacheEnough, DataStream, level, stream_done, underflow
    );

    // Cache side.
    modport slave (
        input  start, in_valid, in_data, DataRequest,
        output in_ready, CacheEnough, DataStream, level, stream_done, underflow
    );
endinterface

// File: rtl/cache_dpram.sv
// cache_dpram
//   Simple dual-port RAM: one synchronous write port and one read port with a
//   registered output. The output register is reset to 0 and only loads on
//   re_i, so it holds the last word read otherwise. Array contents are not
//   reset.
//
//   Ports:
//     clk      clock
//     rst      synchronous active-high reset (output register only)
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     re_i     read enable
//     raddr_i  read address
//     rdata_o  registered read data
module cache_dpram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_stream_cache.sv
// data_stream_cache
//   Small FIFO cache between an upstream word source and HashCore. A stream
//   of LENGTH_ARRAY words is accepted in LOAD; once all of them have been
//   accepted the cache drains in TAIL, and DONE is reached when all of them
//   have been popped. A new start pulse in IDLE or DONE begins the next
//   stream.
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     stream_if  stream handshake bundle (slave side)
//     state_o    current stream state, for observation
module data_stream_cache
    import data_stream_cache_pkg::*;
#(
    parameter int LENGTH_ARRAY     = 100,
    parameter int DATA_INDEX_WIDTH = 32,
    parameter int CACHE_DEPTH_BIT  = 4,
    parameter int THRESHOLD        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    data_stream_cache_if.slave   stream_if,
    output state_t               state_o
);
    localparam int CNT_W = clog2(LENGTH_ARRAY + 1);
    localparam int LVL_W = CACHE_DEPTH_BIT + 1;

    localparam logic [LVL_W-1:0] LVL_FULL = {1'b1, {CACHE_DEPTH_BIT{1'b0}}};
    localparam logic [LVL_W-1:0] LVL_THR  = LVL_W'(THRESHOLD);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LENGTH_ARRAY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CACHE_DEPTH_BIT-1:0] PTR_ONE = CACHE_DEPTH_BIT'(1);

    state_t                     state_q,     state_d;
    logic [CACHE_DEPTH_BIT-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CACHE_DEPTH_BIT-1:0] rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0]           level_q,     level_d;
    logic [CNT_W-1:0]           in_cnt_q,    in_cnt_d;
    logic [CNT_W-1:0]           out_cnt_q,   out_cnt_d;
    logic                       underflow_q, underflow_d;

    logic                        active;
    logic                        in_ready;
    logic                        push;
    logic                        pop;
    logic [DATA_INDEX_WIDTH-1:0] rdata;

    assign active   = (state_q == ST_LOAD) || (state_q == ST_TAIL);
    assign in_ready = (state_q == ST_LOAD) && (level_q < LVL_FULL);
    assign push     = stream_if.in_valid && in_ready;
    // Pops are allowed below THRESHOLD in LOAD; CacheEnough is only a hint.
    assign pop      = stream_if.DataRequest && active && (level_q != '0);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        underflow_d = underflow_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (stream_if.start) begin
                    state_d     = ST_LOAD;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    level_d     = '0;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    underflow_d = 1'b0;
                end else if (stream_if.DataRequest) begin
                    underflow_d = 1'b1;
                end
            end
            default: begin
                // LOAD or TAIL; start is ignored here.
                if (stream_if.DataRequest && !pop) begin
                    underflow_d = 1'b1;
                end
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (in_cnt_q != LEN_C) begin
                        in_cnt_d = in_cnt_q + CNT_ONE;
                    end
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (out_cnt_q != LEN_C) begin
                        out_cnt_d = out_cnt_q + CNT_ONE;
                    end
                end
                case ({push, pop})
                    2'b10:   level_d = level_q + LVL_ONE;
                    2'b01:   level_d = level_q - LVL_ONE;
                    default: level_d = level_q;
                endcase
                // Pops never outrun pushes, so the popped count can only
                // reach the stream length after LOAD has moved to TAIL.
                if ((state_q == ST_LOAD) && (in_cnt_d == LEN_C)) begin
                    state_d = ST_TAIL;
                end else if ((state_q == ST_TAIL) && (out_cnt_d == LEN_C)) begin
                    state_d = ST_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    cache_dpram #(
        .DATA_W (DATA_INDEX_WIDTH),
        .ADDR_W (CACHE_DEPTH_BIT)
    ) u_cache_dpram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (stream_if.in_data),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign stream_if.in_ready    = in_ready;
    assign stream_if.CacheEnough = ((state_q == ST_LOAD) && (level_q >= LVL_THR)) ||
                                   ((state_q == ST_TAIL) && (level_q != '0));
    assign stream_if.DataStream  = rdata;
    assign stream_if.level       = level_q;
    assign stream_if.stream_done = (state_q == ST_DONE);
    assign stream_if.underflow   = underflow_q;
    assign state_o               = state_q;
endmodule

// File: tb/tb_data_stream_cache.sv
// tb_data_stream_cache
//   Two caches share one stimulus stream: dut_a with a 100-word stream and
//   dut_b with a 6-word stream. A stream-level model (words indexed by their
//   position in the stream, level = accepted - popped) predicts every output
//   of both instances each cycle; directed literal checks pin the model.
module tb_data_stream_cache;
    import data_stream_cache_pkg::*;

    localparam int DW    = 32;
    localparam int CDB   = 4;
    localparam int DEPTH = 16;
    localparam int THR   = 4;
    localparam int LEN_A = 100;
    localparam int LEN_B = 6;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_TAIL = 2;
    localparam int M_DONE = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          DataRequest;

    data_stream_cache_if #(.DATA_INDEX_WIDTH(DW), .CACHE_DEPTH_BIT(CDB)) if_a ();
    data_stream_cache_if #(.DATA_INDEX_WIDTH(DW), .CACHE_DEPTH_BIT(CDB)) if_b ();

    assign if_a.start       = start;
    assign if_a.in_valid    = in_valid;
    assign if_a.in_data     = in_data;
    assign if_a.DataRequest = DataRequest;
    assign if_b.start       = start;
    assign if_b.in_valid    = in_valid;
    assign if_b.in_data     = in_data;
    assign if_b.DataRequest = DataRequest;

    state_t st_a;
    state_t st_b;

    data_stream_cache #(
        .LENGTH_ARRAY(LEN_A), .DATA_INDEX_WIDTH(DW),
        .CACHE_DEPTH_BIT(CDB), .THRESHOLD(THR)
    ) dut_a (
        .clk(clk), .rst(rst), .stream_if(if_a), .state_o(st_a)
    );

    data_stream_cache #(
        .LENGTH_ARRAY(LEN_B), .DATA_INDEX_WIDTH(DW),
        .CACHE_DEPTH_BIT(CDB), .THRESHOLD(THR)
    ) dut_b (
        .clk(clk), .rst(rst), .stream_if(if_b), .state_o(st_b)
    );

    // DUT outputs gathered per instance
    logic [1:0]    d_st  [2];
    logic [CDB:0]  d_lvl [2];
    logic          d_rdy [2];
    logic          d_ce  [2];
    logic [DW-1:0] d_ds  [2];
    logic          d_sd  [2];
    logic          d_uf  [2];
    assign d_st[0]  = st_a;             assign d_st[1]  = st_b;
    assign d_lvl[0] = if_a.level;       assign d_lvl[1] = if_b.level;
    assign d_rdy[0] = if_a.in_ready;    assign d_rdy[1] = if_b.in_ready;
    assign d_ce[0]  = if_a.CacheEnough; assign d_ce[1]  = if_b.CacheEnough;
    assign d_ds[0]  = if_a.DataStream;  assign d_ds[1]  = if_b.DataStream;
    assign d_sd[0]  = if_a.stream_done; assign d_sd[1]  = if_b.stream_done;
    assign d_uf[0]  = if_a.underflow;   assign d_uf[1]  = if_b.underflow;

    // ---------------- check bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- stream model ----------------
    int            m_st  [2];
    int            m_in  [2];
    int            m_out [2];
    logic [DW-1:0] m_ds  [2];
    bit            m_uf  [2];
    logic [DW-1:0] m_words [2][128];

    function automatic int len_of(input int k);
        return (k == 0) ? LEN_A : LEN_B;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_st[k]  = M_IDLE;
            m_in[k]  = 0;
            m_out[k] = 0;
            m_ds[k]  = '0;
            m_uf[k]  = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int            lvl;
            int            nst;
            int            nin;
            int            nout;
            bit            nuf;
            bit            push;
            bit            pop;
            logic [DW-1:0] nds;
            lvl  = m_in[k] - m_out[k];
            nst  = m_st[k];
            nin  = m_in[k];
            nout = m_out[k];
            nuf  = m_uf[k];
            nds  = m_ds[k];
            if (rst) begin
                nst = M_IDLE; nin = 0; nout = 0; nuf = 1'b0; nds = '0;
            end else if (m_st[k] == M_IDLE || m_st[k] == M_DONE) begin
                if (start) begin
                    nst = M_LOAD; nin = 0; nout = 0; nuf = 1'b0;
                end else if (DataRequest) begin
                    nuf = 1'b1;
                end
            end else begin
                push = in_valid && (m_st[k] == M_LOAD) && (lvl < DEPTH);
                pop  = DataRequest && (lvl > 0);
                if (DataRequest && !pop) nuf = 1'b1;
                if (pop) begin
                    nds  = m_words[k][m_out[k]];
                    nout = nout + 1;
                end
                if (push) begin
                    m_words[k][m_in[k]] <= in_data;
                    nin = nin + 1;
                end
                if (m_st[k] == M_LOAD && nin == len_of(k)) nst = M_TAIL;
                else if (m_st[k] == M_TAIL && nout == len_of(k)) nst = M_DONE;
            end
            m_st[k]  <= nst;
            m_in[k]  <= nin;
            m_out[k] <= nout;
            m_uf[k]  <= nuf;
            m_ds[k]  <= nds;
        end
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int    lvl;
                string p;
                lvl = m_in[k] - m_out[k];
                p   = (k == 0) ? "a" : "b";
                chk({p, ".state"},       32'(d_st[k]),  32'(m_st[k]));
                chk({p, ".level"},       32'(d_lvl[k]), 32'(lvl));
                chk({p, ".in_ready"},    32'(d_rdy[k]), 32'((m_st[k] == M_LOAD) && (lvl < DEPTH)));
                chk({p, ".CacheEnough"}, 32'(d_ce[k]),
                    32'(((m_st[k] == M_LOAD) && (lvl >= THR)) || ((m_st[k] == M_TAIL) && (lvl > 0))));
                chk({p, ".DataStream"},  d_ds[k],       m_ds[k]);
                chk({p, ".stream_done"}, 32'(d_sd[k]),  32'(m_st[k] == M_DONE));
                chk({p, ".underflow"},   32'(d_uf[k]),  32'(m_uf[k]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [DW-1:0] exp_q[$];

    // Apply one cycle of inputs (called just after a falling edge) and
    // return at the next falling edge.
    task automatic step(input logic s, input logic v, input logic [DW-1:0] d, input logic r);
        start       = s;
        in_valid    = v;
        in_data     = d;
        DataRequest = r;
        @(negedge clk);
        start       = 1'b0;
        in_valid    = 1'b0;
        DataRequest = 1'b0;
    endtask

    task automatic push_w(input logic [DW-1:0] d);
        step(1'b0, 1'b1, d, 1'b0);
        exp_q.push_back(d);
    endtask

    task automatic pop_chk();
        logic [DW-1:0] e;
        step(1'b0, 1'b0, '0, 1'b1);
        if (exp_q.size() == 0) begin
            chk("a.exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("a.pop_order", if_a.DataStream, e);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] e;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; DataRequest = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        // reset state
        chk("rst.state",       32'(st_a), 32'(M_IDLE));
        chk("rst.level",       32'(if_a.level), 32'd0);
        chk("rst.in_ready",    32'(if_a.in_ready), 32'd0);
        chk("rst.CacheEnough", 32'(if_a.CacheEnough), 32'd0);
        chk("rst.DataStream",  if_a.DataStream, 32'h0);
        chk("rst.stream_done", 32'(if_a.stream_done), 32'd0);
        chk("rst.underflow",   32'(if_a.underflow), 32'd0);
        rst = 1'b0;

        // fill: CacheEnough rises the cycle after the 4th push
        step(1'b1, 1'b0, '0, 1'b0);
        chk("fill.state_load", 32'(st_a), 32'(M_LOAD));
        for (int i = 0; i < 4; i++) begin
            push_w(DW'(32'h10 + i));
            if (i == 2) chk("fill.ce_at_3", 32'(if_a.CacheEnough), 32'd0);
        end
        chk("fill.level4", 32'(if_a.level), 32'd4);
        chk("fill.ce_at_4", 32'(if_a.CacheEnough), 32'd1);
        for (int i = 0; i < 4; i++) pop_chk();

        // order: 16 words in, 16 out
        for (int i = 0; i < 16; i++) push_w(DW'(32'hA0 + i));
        chk("order.level16", 32'(if_a.level), 32'd16);
        chk("order.full_rdy", 32'(if_a.in_ready), 32'd0);
        for (int i = 0; i < 16; i++) pop_chk();
        chk("order.level0", 32'(if_a.level), 32'd0);
        chk("order.last", if_a.DataStream, 32'hAF);

        // full / wrap: offer 20, only 16 accepted
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, DW'(32'hB0 + i), 1'b0);
            if (i < 16) exp_q.push_back(DW'(32'hB0 + i));
        end
        chk("full.level16", 32'(if_a.level), 32'd16);
        chk("full.rdy_low", 32'(if_a.in_ready), 32'd0);
        pop_chk();
        chk("full.first_b0", if_a.DataStream, 32'hB0);
        chk("full.rdy_back", 32'(if_a.in_ready), 32'd1);
        push_w(32'hD0);
        chk("full.level_again", 32'(if_a.level), 32'd16);
        for (int i = 0; i < 16; i++) pop_chk();
        chk("wrap.last_d0", if_a.DataStream, 32'hD0);

        // simultaneous push and pop at level 3
        push_w(32'hE0); push_w(32'hE1); push_w(32'hE2);
        chk("sim.level3_pre", 32'(if_a.level), 32'd3);
        step(1'b0, 1'b1, 32'hE3, 1'b1);
        exp_q.push_back(32'hE3);
        e = exp_q.pop_front();
        chk("sim.pop_e0", if_a.DataStream, e);
        chk("sim.level3_post", 32'(if_a.level), 32'd3);
        for (int i = 0; i < 3; i++) pop_chk();
        chk("sim.uf_clear", 32'(if_a.underflow), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("uf.set", 32'(if_a.underflow), 32'd1);
        chk("uf.level0", 32'(if_a.level), 32'd0);
        chk("uf.ds_hold", if_a.DataStream, 32'hE3);

        // tail on the 6-word instance; dut_a ignores start in LOAD
        chk("tail.b_done_before", 32'(st_b), 32'(M_DONE));
        step(1'b1, 1'b0, '0, 1'b0);
        chk("tail.a_ignores_start", 32'(st_a), 32'(M_LOAD));
        chk("tail.a_uf_kept", 32'(if_a.underflow), 32'd1);
        chk("tail.b_load", 32'(st_b), 32'(M_LOAD));
        chk("tail.b_uf_cleared", 32'(if_b.underflow), 32'd0);
        for (int i = 0; i < 6; i++) push_w(DW'(32'h60 + i));
        chk("tail.b_state", 32'(st_b), 32'(M_TAIL));
        chk("tail.b_level6", 32'(if_b.level), 32'd6);
        chk("tail.b_rdy_low", 32'(if_b.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) pop_chk();
        chk("tail.b_level1", 32'(if_b.level), 32'd1);
        chk("tail.b_ce_at_1", 32'(if_b.CacheEnough), 32'd1);
        chk("tail.a_ce_at_1", 32'(if_a.CacheEnough), 32'd0);
        chk("tail.b_not_done", 32'(if_b.stream_done), 32'd0);
        pop_chk();
        chk("tail.b_ds_65", if_b.DataStream, 32'h65);
        chk("tail.b_done", 32'(if_b.stream_done), 32'd1);
        chk("tail.b_state_done", 32'(st_b), 32'(M_DONE));

        // reset mid-LOAD at level 5
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DW'(32'h70 + i), 1'b0);
        chk("rst2.level5", 32'(if_a.level), 32'd5);
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        chk("rst2.state", 32'(st_a), 32'(M_IDLE));
        chk("rst2.level", 32'(if_a.level), 32'd0);
        chk("rst2.ds", if_a.DataStream, 32'h0);
        chk("rst2.uf", 32'(if_a.underflow), 32'd0);
        chk("rst2.rdy", 32'(if_a.in_ready), 32'd0);
        chk("rst2.ce", 32'(if_a.CacheEnough), 32'd0);
        chk("rst2.b_done", 32'(if_b.stream_done), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("rst2.req_uf", 32'(if_a.underflow), 32'd1);
        chk("rst2.req_ds", if_a.DataStream, 32'h0);
        chk("rst2.req_level", 32'(if_a.level), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("rst2.no_emit", if_a.DataStream, 32'h0);

        // new stream after reset
        step(1'b1, 1'b0, '0, 1'b0);
        push_w(32'h80); push_w(32'h81);
        pop_chk(); pop_chk();
        chk("restart.level0", 32'(if_a.level), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
